ps2_note_decoder: RTL and testbench
===================================

// Module: ps2_note_decoder
// PURPOSE
//   Consumes the byte stream from the PS/2 receiver: one-cycle strobe plus an 8-bit set-2 scancode.
//   Decodes make/break prefixes and maps 13 piano-layout keys to note-on/note-off events.
//   Also maps two octave-shift keys. Sits between the PS/2 receiver and the synth voice allocator.
//   Suppresses typematic auto-repeat and keeps a held-key bitmap.
// PARAMETERS
//   OCT_RESET    3       octave value after reset (0..OCT_MAX)
//   OCT_MAX      7       highest octave; octave register is 3 bits
//   TIMEOUT_CYC  100000  idle clk cycles before an open prefix (F0/E0) is abandoned (2 ms at 50 MHz)
// PORTS
//   clk         in   1   system clock, 50 MHz
//   reset       in   1   asynchronous, active-low reset
//   byte_valid  in   1   one-cycle strobe: byte_data holds a new scancode byte
//   byte_data   in   8   scancode byte (set 2)
//   note_valid  out  1   one-cycle event strobe
//   note_on     out  1   1 = key press, 0 = key release; valid with note_valid
//   note_key    out  4   key index 0..12 (C..C'); valid with note_valid
//   note_oct    out  3   octave for the event; valid with note_valid
//   octave      out  3   current octave register
//   held        out  13  bit k = key k currently held
// BEHAVIOUR
//   Reset values (async, reset=0):
//     - state=IDLE; octave=OCT_RESET; all other outputs, held and the timeout counter are 0.
//   Key map (index:code):
//     0:1C 1:1D 2:1B 3:24 4:23 5:2B 6:2C 7:34 8:35 9:33 10:3C 11:3B 12:42.
//     Octave down = 1A (Z); octave up = 22 (X). All other codes are unmapped.
//   Bytes are processed only on cycles with byte_valid=1, back-to-back strobes included.
//   FSM (state changes on a byte):
//     IDLE:
//       F0 -> BRK; E0 -> EXT;
//       E1, AA, FA, FE, EE, 00, FF -> ignored, stay IDLE;
//       any other byte -> make handling, stay IDLE.
//     BRK:  any byte -> break handling, then IDLE (a second F0 is treated as an unmapped code).
//     EXT:  F0 -> EXT_BRK; any other byte -> IDLE, no event (extended keys are not mapped).
//     EXT_BRK: any byte -> IDLE, no event.
//   Make, mapped key k:
//     - held[k]=0: set held[k]; emit note_on=1, note_key=k, note_oct=octave.
//     - held[k]=1: typematic repeat, no event.
//   Break, mapped key k:
//     - held[k]=1: clear held[k]; emit note_on=0, note_key=k, note_oct=octave.
//     - held[k]=0: no event.
//   Octave keys act on make only, and only when held==0; otherwise ignored.
//     - Down saturates at 0; up saturates at OCT_MAX. No note event.
//     - Octave breaks are ignored. Because of the held==0 rule, note_oct on a release always equals the press octave.
//   Unmapped make/break codes are silent.
//   Latency: note_valid, note_on, note_key, note_oct, held and octave all update on the clk edge that samples byte_valid.
//     - note_valid is high for exactly 1 cycle per event.
//     - note_on, note_key and note_oct hold their values until the next event.
//   Timeout counter:
//     - Cleared on every byte_valid.
//     - Counts while state != IDLE.
//     - On reaching TIMEOUT_CYC-1: state -> IDLE and counter -> 0. held is unchanged.
//     - A byte_valid in the same cycle as the timeout wins: the byte is decoded in the current state.
//   Reset mid-sequence (e.g. after F0): returns to IDLE with held cleared. No release events are emitted.
// TESTING
//   1. Bytes 1C, F0, 1C -> note_valid pulses on/k0/oct3, then off/k0/oct3; held 0x0001 then 0x0000.
//   2. Bytes 1D, 1D, 1D, F0, 1D -> exactly 2 events (on k1, off k1); repeats are silent.
//   3. Bytes 22 x5 (no keys held) -> octave 4,5,6,7,7. Then 1A x8 -> octave 6..0, saturating at 0.
//   4. Hold 42 (k12), then 22 -> octave stays 3. Then F0 42 -> off k12/oct3, held 0.
//   5. Bytes E0 75, then E0 F0 75, then F0 33 (H not held) -> no events; state IDLE after each sequence.
//   6. F0, then idle TIMEOUT_CYC cycles, then 1C -> note_on k0, not a break.
//      Also: reset low while in BRK with held=0x0005 -> held=0, outputs 0, octave=3.

Source files
------------

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scancode decoder: turns make/break byte sequences for 13 piano keys into
// note-on/note-off events, with octave shift keys, auto-repeat suppression and a held-key map.
module ps2_note_decoder #(
  parameter int unsigned OCT_RESET   = 3,
  parameter int unsigned OCT_MAX     = 7,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        note_valid,
  output logic        note_on,
  output logic [3:0]  note_key,
  output logic [2:0]  note_oct,
  output logic [2:0]  octave,
  output logic [12:0] held
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [2:0]       OCT_RST = 3'(OCT_RESET);
  localparam logic [2:0]       OCT_TOP = 3'(OCT_MAX);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [12:0]      held_q, held_d;
  logic [2:0]       oct_q, oct_d;
  logic             valid_q, valid_d;
  logic             on_q, on_d;
  logic [3:0]       key_q, key_d;
  logic [2:0]       noct_q, noct_d;

  logic             key_hit;
  logic [3:0]       key_idx;

  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    case (byte_data)
      8'h1C: key_idx = 4'd0;
      8'h1D: key_idx = 4'd1;
      8'h1B: key_idx = 4'd2;
      8'h24: key_idx = 4'd3;
      8'h23: key_idx = 4'd4;
      8'h2B: key_idx = 4'd5;
      8'h2C: key_idx = 4'd6;
      8'h34: key_idx = 4'd7;
      8'h35: key_idx = 4'd8;
      8'h33: key_idx = 4'd9;
      8'h3C: key_idx = 4'd10;
      8'h3B: key_idx = 4'd11;
      8'h42: key_idx = 4'd12;
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    oct_d   = oct_q;
    valid_d = 1'b0;
    on_d    = on_q;
    key_d   = key_q;
    noct_d  = noct_q;

    if (byte_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (byte_data)
            8'hF0: state_d = ST_BRK;
            8'hE0: state_d = ST_EXT;
            8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: begin
              if (key_hit) begin
                if (!held_q[key_idx]) begin
                  held_d[key_idx] = 1'b1;
                  valid_d = 1'b1;
                  on_d    = 1'b1;
                  key_d   = key_idx;
                  noct_d  = oct_q;
                end
              end else if (held_q == '0) begin
                // Octave moves only with no key down, so releases keep their press octave.
                if (byte_data == 8'h1A && oct_q != 3'd0)    oct_d = oct_q - 3'd1;
                if (byte_data == 8'h22 && oct_q != OCT_TOP) oct_d = oct_q + 3'd1;
              end
            end
          endcase
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (key_hit && held_q[key_idx]) begin
            held_d[key_idx] = 1'b0;
            valid_d = 1'b1;
            on_d    = 1'b0;
            key_d   = key_idx;
            noct_d  = oct_q;
          end
        end
        ST_EXT:  state_d = (byte_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Abandon a prefix whose follow-up byte never arrived.
      if (cnt_q == CNT_END) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      oct_q   <= OCT_RST;
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      key_q   <= 4'd0;
      noct_q  <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      oct_q   <= oct_d;
      valid_q <= valid_d;
      on_q    <= on_d;
      key_q   <= key_d;
      noct_q  <= noct_d;
    end
  end

  assign note_valid = valid_q;
  assign note_on    = on_q;
  assign note_key   = key_q;
  assign note_oct   = noct_q;
  assign octave     = oct_q;
  assign held       = held_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Self-checking bench for ps2_note_decoder: directed scancode sequences plus random byte
// streams compared against a prefix-queue model of the make/break protocol.
module tb_ps2_note_decoder;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        note_valid;
  logic        note_on;
  logic [3:0]  note_key;
  logic [2:0]  note_oct;
  logic [2:0]  octave;
  logic [12:0] held;

  ps2_note_decoder #(.OCT_RESET(3), .OCT_MAX(7), .TIMEOUT_CYC(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .note_valid (note_valid),
    .note_on    (note_on),
    .note_key   (note_key),
    .note_oct   (note_oct),
    .octave     (octave),
    .held       (held)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ev_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending prefix bytes are kept literally in a queue.
  logic [7:0]  key_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                  8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  logic [7:0]  pre [$];
  logic [12:0] m_held;
  int          m_oct;
  bit          m_ev;
  bit          m_on;
  int          m_key;
  int          m_noct;

  function automatic int key_of(input logic [7:0] b);
    for (int i = 0; i < 13; i++) if (key_codes[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    pre.delete();
    m_held = '0; m_oct = 3; m_ev = 0; m_on = 0; m_key = 0; m_noct = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    m_ev = 0;
    k = key_of(b);
    if (pre.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pre.push_back(b);
      else if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) ;
      else if (k >= 0) begin
        if (!m_held[k]) begin
          m_held[k] = 1'b1; m_ev = 1; m_on = 1; m_key = k; m_noct = m_oct;
        end
      end else if (m_held == 0) begin
        if (b == 8'h1A && m_oct > 0) m_oct--;
        if (b == 8'h22 && m_oct < 7) m_oct++;
      end
    end else if (pre.size() == 1 && pre[0] == 8'hF0) begin
      pre.delete();
      if (k >= 0 && m_held[k]) begin
        m_held[k] = 1'b0; m_ev = 1; m_on = 0; m_key = k; m_noct = m_oct;
      end
    end else if (pre.size() == 1 && b == 8'hF0) begin
      pre.push_back(b);
    end else begin
      pre.delete();
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(note_valid), 32'(m_ev));
    check({tag, ".on"},    32'(note_on),    32'(m_on));
    check({tag, ".key"},   32'(note_key),   32'(m_key));
    check({tag, ".noct"},  32'(note_oct),   32'(m_noct));
    check({tag, ".held"},  32'(held),       32'(m_held));
    check({tag, ".oct"},   32'(octave),     32'(m_oct));
    if (note_valid === 1'b1) ev_seen++;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    model_byte(b);
    compare_all($sformatf("byte%02h", b));
  endtask

  // Gaps are either well below or well above the timeout, never at the boundary.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("idle.valid", 32'(note_valid), 32'd0);
    end
    if (n >= T + 2) pre.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] pool [22] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                            8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h1A, 8'h22, 8'hF0,
                            8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'hAA, 8'h75};

  initial begin
    int e0;
    int r;
    reset = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    model_reset();
    #25;
    compare_all("por");
    @(negedge clk);
    reset = 1'b1;

    send(8'h1C); send(8'hF0); send(8'h1C);

    e0 = ev_seen;
    send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
    check("repeat.events", 32'(ev_seen - e0), 32'd2);

    repeat (5) send(8'h22);
    repeat (8) send(8'h1A);
    repeat (3) send(8'h22);

    send(8'h42); send(8'h22); send(8'hF0); send(8'h42);

    e0 = ev_seen;
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h33);
    send(8'h1B); send(8'hF0); send(8'h1B);
    check("ext.events", 32'(ev_seen - e0), 32'd2);

    send(8'h1C); send(8'hF0); idle(T - 4); send(8'h1C);
    send(8'hF0); idle(T + 4); send(8'h1C);
    check("timeout.make", 32'(note_on), 32'd1);

    send(8'h1B); send(8'hF0);
    check("pre_reset.held", 32'(held), 32'h0005);
    do_reset();
    send(8'h1C);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) send(pool[$urandom_range(0, 21)]);
      else send(8'($urandom));
      r = int'($urandom_range(0, 19));
      if (r >= 19) idle(T + 4);
      else if (r >= 13) idle(r - 12);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
